// File: rtl/abr_prim_fifo_sync.sv
// rtl/abr_prim_fifo_sync.sv - synchronous ready/valid FIFO with its pointer-pair counter
// Optional pass-through when empty is enabled by defining ABR_FIFO_SYNC_PASS_EN.

module abr_prim_fifo_sync_cnt #(
  parameter int Depth  = 4,
  parameter int Width  = 3,
  parameter bit Secure = 1'b0
) (
  input  logic             clk_i,
  input  logic             rst_b,
  input  logic             clr_i,
  input  logic             incr_wptr_i,
  input  logic             incr_rptr_i,
  output logic [Width-1:0] wptr_o,
  output logic [Width-1:0] rptr_o,
  output logic             err_o
);

  localparam int IdxW = Width - 1;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(Depth - 1);

  logic [Width-1:0] wptr_q, wptr_d;
  logic [Width-1:0] rptr_q, rptr_d;

  // The MSB is a wrap flag, toggled whenever the index rolls over Depth-1 -> 0.
  function automatic logic [Width-1:0] ptr_inc(input logic [Width-1:0] p);
    logic [Width-1:0] n;
    if (p[IdxW-1:0] == LastIdx) begin
      n = {~p[Width-1], {IdxW{1'b0}}};
    end else begin
      n = {p[Width-1], p[IdxW-1:0] + IdxW'(1)};
    end
    return n;
  endfunction

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    if (clr_i) begin
      wptr_d = '0;
      rptr_d = '0;
    end else begin
      if (incr_wptr_i) wptr_d = ptr_inc(wptr_q);
      if (incr_rptr_i) rptr_d = ptr_inc(rptr_q);
    end
  end

  always_ff @(posedge clk_i or negedge rst_b) begin
    if (!rst_b) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

  assign wptr_o = wptr_q;
  assign rptr_o = rptr_q;

  if (Secure) begin : g_secure
    // Shadow copies held inverted so a stuck node cannot corrupt both identically.
    logic [Width-1:0] wptr_inv_q, rptr_inv_q;
    logic             range_err;

    always_ff @(posedge clk_i or negedge rst_b) begin
      if (!rst_b) begin
        wptr_inv_q <= '1;
        rptr_inv_q <= '1;
      end else begin
        wptr_inv_q <= ~wptr_d;
        rptr_inv_q <= ~rptr_d;
      end
    end

    assign range_err = (int'(wptr_q[IdxW-1:0]) >= Depth) || (int'(rptr_q[IdxW-1:0]) >= Depth);
    assign err_o = (wptr_q != ~wptr_inv_q) || (rptr_q != ~rptr_inv_q) || range_err;
  end else begin : g_plain
    assign err_o = 1'b0;
  end

endmodule

module abr_prim_fifo_sync #(
  parameter int Width  = 32,
  parameter int Depth  = 4,
  parameter bit Secure = 1'b0,
  localparam int PtrW   = $clog2(Depth) + 1,
  localparam int DepthW = $clog2(Depth + 1)
) (
  input  logic              clk_i,
  input  logic              rst_b,
  input  logic              clr_i,
  input  logic              wvalid_i,
  output logic              wready_o,
  input  logic [Width-1:0]  wdata_i,
  output logic              rvalid_o,
  input  logic              rready_i,
  output logic [Width-1:0]  rdata_o,
  output logic              full_o,
  output logic [DepthW-1:0] depth_o,
  output logic              err_o
);

  localparam int IdxW = PtrW - 1;
  localparam int DW1  = DepthW + 1;

  logic [PtrW-1:0]  wptr, rptr;
  logic [IdxW-1:0]  wlow, rlow;
  logic [Width-1:0] storage_q [Depth];
  logic [Width-1:0] storage_d [Depth];
  logic [DW1-1:0]   depth_full;
  logic             empty, full;
  logic             wr_fire, rd_fire, pass;
  logic             incr_w, incr_r, cnt_err;

  abr_prim_fifo_sync_cnt #(
    .Depth  (Depth),
    .Width  (PtrW),
    .Secure (Secure)
  ) u_cnt (
    .clk_i       (clk_i),
    .rst_b       (rst_b),
    .clr_i       (clr_i),
    .incr_wptr_i (incr_w),
    .incr_rptr_i (incr_r),
    .wptr_o      (wptr),
    .rptr_o      (rptr),
    .err_o       (cnt_err)
  );

  always_comb begin
    wlow  = wptr[IdxW-1:0];
    rlow  = rptr[IdxW-1:0];
    empty = (wptr == rptr);
    full  = (wlow == rlow) && (wptr[PtrW-1] != rptr[PtrW-1]);
    if (wptr[PtrW-1] == rptr[PtrW-1]) begin
      depth_full = DW1'(wlow) - DW1'(rlow);
    end else begin
      depth_full = DW1'(Depth) - DW1'(rlow) + DW1'(wlow);
    end
  end

  // Read-side view: the bypass variant exposes the incoming word while empty.
  always_comb begin
`ifdef ABR_FIFO_SYNC_PASS_EN
    rvalid_o = empty ? wvalid_i : 1'b1;
    if (!rvalid_o) begin
      rdata_o = '0;
    end else if (empty) begin
      rdata_o = wdata_i;
    end else begin
      rdata_o = storage_q[rlow];
    end
    pass = empty && wvalid_i && rready_i;
`else
    rvalid_o = ~empty;
    rdata_o  = rvalid_o ? storage_q[rlow] : '0;
    pass     = 1'b0;
`endif
  end

  always_comb begin
    wready_o = ~full;
    full_o   = full;
    depth_o  = depth_full[DepthW-1:0];
    err_o    = cnt_err || (depth_full > DW1'(Depth));
    wr_fire  = wvalid_i && wready_o;
    rd_fire  = rvalid_o && rready_i;
    incr_w   = wr_fire && !pass;
    incr_r   = rd_fire && !pass;
  end

  always_comb begin
    for (int i = 0; i < Depth; i++) storage_d[i] = storage_q[i];
    if (incr_w && !clr_i) storage_d[wlow] = wdata_i;
  end

  always_ff @(posedge clk_i or negedge rst_b) begin
    if (!rst_b) begin
      for (int i = 0; i < Depth; i++) storage_q[i] <= '0;
    end else begin
      for (int i = 0; i < Depth; i++) storage_q[i] <= storage_d[i];
    end
  end

endmodule

// File: tb/tb_abr_prim_fifo_sync.sv
// tb/tb_abr_prim_fifo_sync.sv - directed vector bench for abr_prim_fifo_sync (Depth 4 and Depth 3)

module tb_abr_prim_fifo_sync;

  logic clk = 1'b0;
  logic rst_b = 1'b0;
  always #5 clk = ~clk;

  logic       a_clr, a_wvalid, a_wready, a_rvalid, a_rready, a_full, a_err;
  logic [7:0] a_wdata, a_rdata;
  logic [2:0] a_depth;

  logic       b_clr, b_wvalid, b_wready, b_rvalid, b_rready, b_full, b_err;
  logic [7:0] b_wdata, b_rdata;
  logic [1:0] b_depth;

  abr_prim_fifo_sync #(.Width(8), .Depth(4)) u4 (
    .clk_i(clk), .rst_b(rst_b), .clr_i(a_clr),
    .wvalid_i(a_wvalid), .wready_o(a_wready), .wdata_i(a_wdata),
    .rvalid_o(a_rvalid), .rready_i(a_rready), .rdata_o(a_rdata),
    .full_o(a_full), .depth_o(a_depth), .err_o(a_err)
  );

  abr_prim_fifo_sync #(.Width(8), .Depth(3)) u3 (
    .clk_i(clk), .rst_b(rst_b), .clr_i(b_clr),
    .wvalid_i(b_wvalid), .wready_o(b_wready), .wdata_i(b_wdata),
    .rvalid_o(b_rvalid), .rready_i(b_rready), .rdata_o(b_rdata),
    .full_o(b_full), .depth_o(b_depth), .err_o(b_err)
  );

  typedef struct {
    logic       clr;
    logic       wvalid;
    logic [7:0] wdata;
    logic       rready;
    logic       rvalid;
    logic [7:0] rdata;
    logic       wready;
    logic       full;
    logic [2:0] depth;
  } vec_t;

  vec_t vecs[22];
  int total = 0;
  int bad = 0;

  function automatic vec_t mk(logic c, logic wv, logic [7:0] wd, logic rr,
                              logic rv, logic [7:0] rd, logic wr, logic fu, logic [2:0] dp);
    vec_t v;
    v.clr = c; v.wvalid = wv; v.wdata = wd; v.rready = rr;
    v.rvalid = rv; v.rdata = rd; v.wready = wr; v.full = fu; v.depth = dp;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic idle_a();
    a_clr = 1'b0; a_wvalid = 1'b0; a_wdata = 8'h00; a_rready = 1'b0;
  endtask

  initial begin
    logic       exp_rv;
    logic [7:0] exp_rd;
    int         k;

    idle_a();
    b_clr = 1'b0; b_wvalid = 1'b0; b_wdata = 8'h00; b_rready = 1'b0;

    // column order: clr wvalid wdata rready | rvalid rdata wready full depth
    vecs[0]  = mk(0, 1, 8'hA0, 0,  0, 8'h00, 1, 0, 3'd0);
    vecs[1]  = mk(0, 1, 8'hA1, 0,  1, 8'hA0, 1, 0, 3'd1);
    vecs[2]  = mk(0, 1, 8'hA2, 0,  1, 8'hA0, 1, 0, 3'd2);
    vecs[3]  = mk(0, 1, 8'hA3, 0,  1, 8'hA0, 1, 0, 3'd3);
    vecs[4]  = mk(0, 1, 8'hA4, 0,  1, 8'hA0, 0, 1, 3'd4);
    vecs[5]  = mk(0, 1, 8'hA5, 1,  1, 8'hA0, 0, 1, 3'd4);
    vecs[6]  = mk(0, 0, 8'h00, 1,  1, 8'hA1, 1, 0, 3'd3);
    vecs[7]  = mk(0, 0, 8'h00, 1,  1, 8'hA2, 1, 0, 3'd2);
    vecs[8]  = mk(0, 0, 8'h00, 1,  1, 8'hA3, 1, 0, 3'd1);
    vecs[9]  = mk(0, 0, 8'h00, 0,  0, 8'h00, 1, 0, 3'd0);
    vecs[10] = mk(0, 1, 8'hB0, 0,  0, 8'h00, 1, 0, 3'd0);
    vecs[11] = mk(0, 1, 8'hB1, 0,  1, 8'hB0, 1, 0, 3'd1);
    vecs[12] = mk(1, 1, 8'hB2, 0,  1, 8'hB0, 1, 0, 3'd2);
    vecs[13] = mk(0, 0, 8'h00, 0,  0, 8'h00, 1, 0, 3'd0);
    vecs[14] = mk(0, 1, 8'hC0, 0,  0, 8'h00, 1, 0, 3'd0);
    vecs[15] = mk(0, 0, 8'h00, 1,  1, 8'hC0, 1, 0, 3'd1);
    vecs[16] = mk(0, 0, 8'h00, 0,  0, 8'h00, 1, 0, 3'd0);
    vecs[17] = mk(0, 1, 8'hD0, 0,  0, 8'h00, 1, 0, 3'd0);
    vecs[18] = mk(0, 1, 8'hD1, 1,  1, 8'hD0, 1, 0, 3'd1);
    vecs[19] = mk(0, 1, 8'hD2, 1,  1, 8'hD1, 1, 0, 3'd1);
    vecs[20] = mk(0, 0, 8'h00, 1,  1, 8'hD2, 1, 0, 3'd1);
    vecs[21] = mk(0, 0, 8'h00, 0,  0, 8'h00, 1, 0, 3'd0);

    repeat (2) @(negedge clk);
    #1;
    chk("rst_wready", a_wready, 1);
    chk("rst_rvalid", a_rvalid, 0);
    chk("rst_rdata",  a_rdata,  0);
    chk("rst_depth",  a_depth,  0);
    chk("rst_full",   a_full,   0);
    chk("rst_err",    a_err,    0);
    chk("rst_depth3", b_depth,  0);
    @(negedge clk);
    rst_b = 1'b1;

    for (int i = 0; i < 22; i++) begin
      @(negedge clk);
      a_clr = vecs[i].clr; a_wvalid = vecs[i].wvalid;
      a_wdata = vecs[i].wdata; a_rready = vecs[i].rready;
      exp_rv = vecs[i].rvalid;
      exp_rd = vecs[i].rdata;
`ifdef ABR_FIFO_SYNC_PASS_EN
      if (vecs[i].depth == 3'd0 && vecs[i].wvalid) begin
        exp_rv = 1'b1;
        exp_rd = vecs[i].wdata;
      end
`endif
      #1;
      chk($sformatf("v%0d_rvalid", i), a_rvalid, exp_rv);
      chk($sformatf("v%0d_rdata", i),  a_rdata,  exp_rd);
      chk($sformatf("v%0d_wready", i), a_wready, vecs[i].wready);
      chk($sformatf("v%0d_full", i),   a_full,   vecs[i].full);
      chk($sformatf("v%0d_depth", i),  a_depth,  vecs[i].depth);
      chk($sformatf("v%0d_err", i),    a_err,    0);
    end

    // Same-cycle write/read on an empty FIFO: bypass vs. one-cycle latency
    @(negedge clk);
    a_wvalid = 1'b1; a_wdata = 8'h5A; a_rready = 1'b1;
    #1;
`ifdef ABR_FIFO_SYNC_PASS_EN
    chk("pass_rvalid", a_rvalid, 1);
    chk("pass_rdata",  a_rdata,  8'h5A);
    chk("pass_depth",  a_depth,  0);
    @(negedge clk);
    idle_a();
    #1;
    chk("pass_after_depth",  a_depth,  0);
    chk("pass_after_rvalid", a_rvalid, 0);
`else
    chk("lat_rvalid0", a_rvalid, 0);
    chk("lat_rdata0",  a_rdata,  0);
    @(negedge clk);
    idle_a();
    #1;
    chk("lat_rvalid1", a_rvalid, 1);
    chk("lat_rdata1",  a_rdata,  8'h5A);
    chk("lat_depth1",  a_depth,  1);
    @(negedge clk);
    a_rready = 1'b1;
    @(negedge clk);
    idle_a();
    #1;
    chk("lat_drained", a_depth, 0);
`endif

    // Asynchronous reset in the middle of a transfer discards contents
    @(negedge clk);
    a_wvalid = 1'b1; a_wdata = 8'h77;
    @(negedge clk);
    idle_a();
    #1;
    chk("mid_depth_pre", a_depth, 1);
    #2;
    rst_b = 1'b0;
    #1;
    chk("mid_rst_depth",  a_depth,  0);
    chk("mid_rst_rvalid", a_rvalid, 0);
    chk("mid_rst_rdata",  a_rdata,  0);
    chk("mid_rst_wready", a_wready, 1);
    @(negedge clk);
    rst_b = 1'b1;

    // Depth=3 streaming with wrap after one prefill
    @(negedge clk);
    b_wvalid = 1'b1; b_wdata = 8'hE0; b_rready = 1'b0;
    #1;
    chk("s_pre_depth", b_depth, 0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      b_wdata = 8'hE1 + 8'(i); b_rready = 1'b1;
      #1;
      k = i + 1;
      chk($sformatf("s%0d_depth", i),  b_depth,  1);
      chk($sformatf("s%0d_rvalid", i), b_rvalid, 1);
      chk($sformatf("s%0d_rdata", i),  b_rdata,  8'hE0 + 8'(i));
      chk($sformatf("s%0d_wptr", i),   u3.wptr,  ((k / 3) % 2) * 4 + (k % 3));
      chk($sformatf("s%0d_rptr", i),   u3.rptr,  ((i / 3) % 2) * 4 + (i % 3));
    end
    @(negedge clk);
    b_wvalid = 1'b0; b_rready = 1'b1;
    #1;
    chk("s_tail_rdata", b_rdata, 8'hEA);
    chk("s_tail_depth", b_depth, 1);
    @(negedge clk);
    b_rready = 1'b0;
    #1;
    chk("s_empty_rvalid", b_rvalid, 0);

    // Depth=3 fill to full
    for (int i = 0; i < 3; i++) begin
      b_wvalid = 1'b1; b_wdata = 8'hF0 + 8'(i);
      @(negedge clk);
    end
    b_wvalid = 1'b0;
    #1;
    chk("f3_full",   b_full,   1);
    chk("f3_depth",  b_depth,  3);
    chk("f3_wready", b_wready, 0);
    chk("f3_rdata",  b_rdata,  8'hF0);
    chk("f3_err",    b_err,    0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
